// File: rtl/multi_tachometer_interface.sv
// Multi-channel tachometer front end: sync + debounce per channel, windowed
// pulse counting, saturated RPM publish with stall and overflow flags.

module tach_lane #(
   parameter int DEBOUNCE_TICKS = 2,
   parameter int CNT_WIDTH      = 16,
   parameter int RPM_SCALE      = 60,
   parameter int RPM_WIDTH      = 21,
   parameter int STALL_WINDOWS  = 3
) (
   input  logic                 clk_in,
   input  logic                 reset_n_in,
   input  logic                 tick,
   input  logic                 win_close,
   input  logic                 pulse_raw,
   output logic [RPM_WIDTH-1:0] rpm,
   output logic                 stall,
   output logic                 overflow
);
   localparam int DW  = $clog2(DEBOUNCE_TICKS + 1);
   localparam int ZW  = $clog2(STALL_WINDOWS + 1);
   localparam int PRW = (CNT_WIDTH + 32 > RPM_WIDTH) ? CNT_WIDTH + 32 : RPM_WIDTH + 1;

   logic [1:0]           sync;
   logic                 filt;
   logic [DW-1:0]        db_cnt;
   logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
   logic                 ovf, ovf_nxt;
   logic [ZW-1:0]        zcnt;
   logic                 db_done, pulse, cnt_sat;
   logic [PRW-1:0]       prod;

   assign db_done = tick && (sync[1] != filt) && (db_cnt == DW'(DEBOUNCE_TICKS - 1));
   assign pulse   = db_done && sync[1];
   assign cnt_sat = &cnt;
   // Pulse on the closing tick still belongs to the closing window.
   assign cnt_nxt = (pulse && !cnt_sat) ? cnt + 1'b1 : cnt;
   assign ovf_nxt = ovf | (pulse & cnt_sat);
   assign prod    = PRW'(cnt_nxt) * PRW'(RPM_SCALE);
   assign stall   = (zcnt == ZW'(STALL_WINDOWS));

   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         sync     <= '0;
         filt     <= 1'b0;
         db_cnt   <= '0;
         cnt      <= '0;
         ovf      <= 1'b0;
         zcnt     <= '0;
         rpm      <= '0;
         overflow <= 1'b0;
      end else begin
         sync <= {sync[0], pulse_raw};
         if (tick) begin
            if (sync[1] != filt) begin
               if (db_done) begin
                  filt   <= sync[1];
                  db_cnt <= '0;
               end else begin
                  db_cnt <= db_cnt + 1'b1;
               end
            end else begin
               db_cnt <= '0;
            end
         end
         if (win_close) begin
            cnt      <= '0;
            ovf      <= 1'b0;
            rpm      <= (|prod[PRW-1:RPM_WIDTH]) ? '1 : prod[RPM_WIDTH-1:0];
            overflow <= ovf_nxt;
            if (cnt_nxt == '0) zcnt <= stall ? zcnt : zcnt + 1'b1;
            else               zcnt <= '0;
         end else begin
            cnt <= cnt_nxt;
            ovf <= ovf_nxt;
         end
      end
   end
endmodule

module multi_tachometer_interface #(
   parameter int NUM_CH         = 2,
   parameter int TICK_DIV       = 12500,
   parameter int WINDOW_TICKS   = 10000,
   parameter int DEBOUNCE_TICKS = 2,
   parameter int CNT_WIDTH      = 16,
   parameter int RPM_SCALE      = 60,
   parameter int RPM_WIDTH      = 21,
   parameter int STALL_WINDOWS  = 3
) (
   input  logic                        clk_in,
   input  logic                        reset_n_in,
   input  logic [NUM_CH-1:0]           tachometer_pulse_in,
   output logic [NUM_CH*RPM_WIDTH-1:0] rpm_out,
   output logic                        rpm_valid_out,
   output logic [NUM_CH-1:0]           stall_out,
   output logic [NUM_CH-1:0]           overflow_out
);
   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int WW = (WINDOW_TICKS > 1) ? $clog2(WINDOW_TICKS) : 1;

   logic [PW-1:0] pre_cnt;
   logic [WW-1:0] win_cnt;
   logic          tick, win_close;

   assign tick      = (pre_cnt == PW'(TICK_DIV - 1));
   assign win_close = tick && (win_cnt == WW'(WINDOW_TICKS - 1));

   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         pre_cnt       <= '0;
         win_cnt       <= '0;
         rpm_valid_out <= 1'b0;
      end else begin
         pre_cnt       <= tick ? '0 : pre_cnt + 1'b1;
         rpm_valid_out <= win_close;
         if (tick) win_cnt <= win_close ? '0 : win_cnt + 1'b1;
      end
   end

   tach_lane #(
      .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
      .CNT_WIDTH      (CNT_WIDTH),
      .RPM_SCALE      (RPM_SCALE),
      .RPM_WIDTH      (RPM_WIDTH),
      .STALL_WINDOWS  (STALL_WINDOWS)
   ) u_lane [NUM_CH-1:0] (
      .clk_in     (clk_in),
      .reset_n_in (reset_n_in),
      .tick       (tick),
      .win_close  (win_close),
      .pulse_raw  (tachometer_pulse_in),
      .rpm        (rpm_out),
      .stall      (stall_out),
      .overflow   (overflow_out)
   );
endmodule

// File: tb/tb_multi_tachometer_interface.sv
// Bench for multi_tachometer_interface: three parameter sets share one stimulus
// and are checked every cycle against a tick-level behavioural model.

module tb_multi_tachometer_interface;
   localparam int TD = 4, WT = 20, DB = 2, SW = 3;
   localparam longint CMAX [3] = '{65535, 3, 3};
   localparam longint SCL  [3] = '{60, 60, 100};
   localparam longint RMAX [3] = '{2097151, 255, 255};

   logic        clk = 1'b0, rst_n = 1'b0;
   logic [1:0]  tach = 2'b00;
   logic [41:0] rpm_a;
   logic [15:0] rpm_b, rpm_c;
   logic        vld_a, vld_b, vld_c;
   logic [1:0]  st_a, st_b, st_c, ov_a, ov_b, ov_c;

   int n_pass = 0, n_tot = 0;
   int mode = 0;

   always #5 clk = ~clk;

   multi_tachometer_interface #(.NUM_CH(2), .TICK_DIV(TD), .WINDOW_TICKS(WT), .DEBOUNCE_TICKS(DB),
      .CNT_WIDTH(16), .RPM_SCALE(60), .RPM_WIDTH(21), .STALL_WINDOWS(SW)) u_dut_a (
      .clk_in(clk), .reset_n_in(rst_n), .tachometer_pulse_in(tach), .rpm_out(rpm_a),
      .rpm_valid_out(vld_a), .stall_out(st_a), .overflow_out(ov_a));
   multi_tachometer_interface #(.NUM_CH(2), .TICK_DIV(TD), .WINDOW_TICKS(WT), .DEBOUNCE_TICKS(DB),
      .CNT_WIDTH(2), .RPM_SCALE(60), .RPM_WIDTH(8), .STALL_WINDOWS(SW)) u_dut_b (
      .clk_in(clk), .reset_n_in(rst_n), .tachometer_pulse_in(tach), .rpm_out(rpm_b),
      .rpm_valid_out(vld_b), .stall_out(st_b), .overflow_out(ov_b));
   multi_tachometer_interface #(.NUM_CH(2), .TICK_DIV(TD), .WINDOW_TICKS(WT), .DEBOUNCE_TICKS(DB),
      .CNT_WIDTH(2), .RPM_SCALE(100), .RPM_WIDTH(8), .STALL_WINDOWS(SW)) u_dut_c (
      .clk_in(clk), .reset_n_in(rst_n), .tachometer_pulse_in(tach), .rpm_out(rpm_c),
      .rpm_valid_out(vld_c), .stall_out(st_c), .overflow_out(ov_c));

   task automatic chk(input string name, input longint act, input longint exp);
      n_tot++;
      if (act == exp) n_pass++;
      else $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
   endtask

   // Model state: per-channel filtered level, disagreeing-sample run, true pulse count.
   longint exp_rpm [3][2];
   bit     exp_ovf [3][2];
   bit     exp_stall [2];
   bit     exp_valid;
   bit     filt [2];
   int     mism [2], zwin [2];
   longint cnt [2];
   bit [1:0] prev1, prev2;
   int     m, tickn;

   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m = 0; tickn = 0; exp_valid = 0; prev1 = 0; prev2 = 0;
            for (int c = 0; c < 2; c++) begin
               filt[c] = 0; mism[c] = 0; zwin[c] = 0; cnt[c] = 0; exp_stall[c] = 0;
               for (int i = 0; i < 3; i++) begin exp_rpm[i][c] = 0; exp_ovf[i][c] = 0; end
            end
         end else begin
            m++;
            exp_valid = 0;
            if (m % TD == 0) begin
               // The value the pins had two edges ago is what a tick sees.
               for (int c = 0; c < 2; c++) begin
                  if (prev2[c] != filt[c]) begin
                     mism[c]++;
                     if (mism[c] == DB) begin
                        filt[c] = prev2[c]; mism[c] = 0;
                        if (filt[c]) cnt[c]++;
                     end
                  end else mism[c] = 0;
               end
               tickn++;
               if (tickn % WT == 0) begin
                  exp_valid = 1;
                  for (int c = 0; c < 2; c++) begin
                     for (int i = 0; i < 3; i++) begin
                        longint cc, r;
                        cc = (cnt[c] > CMAX[i]) ? CMAX[i] : cnt[c];
                        r  = cc * SCL[i];
                        exp_rpm[i][c] = (r > RMAX[i]) ? RMAX[i] : r;
                        exp_ovf[i][c] = (cnt[c] > CMAX[i]);
                     end
                     if (cnt[c] == 0) zwin[c] = (zwin[c] < SW) ? zwin[c] + 1 : SW;
                     else             zwin[c] = 0;
                     exp_stall[c] = (zwin[c] == SW);
                     cnt[c] = 0;
                  end
               end
            end
            prev2 = prev1;
            prev1 = tach;
         end
      end
   end

   // Every-cycle comparison of all three DUTs against the model.
   initial begin
      forever begin
         @(negedge clk);
         chk("valid_a", vld_a, exp_valid);
         chk("valid_b", vld_b, exp_valid);
         chk("valid_c", vld_c, exp_valid);
         chk("stall_a", st_a, {exp_stall[1], exp_stall[0]});
         chk("stall_b", st_b, {exp_stall[1], exp_stall[0]});
         chk("stall_c", st_c, {exp_stall[1], exp_stall[0]});
         chk("ovf_a", ov_a, {exp_ovf[0][1], exp_ovf[0][0]});
         chk("ovf_b", ov_b, {exp_ovf[1][1], exp_ovf[1][0]});
         chk("ovf_c", ov_c, {exp_ovf[2][1], exp_ovf[2][0]});
         for (int c = 0; c < 2; c++) begin
            chk($sformatf("rpm_a_ch%0d", c), rpm_a[c*21 +: 21], exp_rpm[0][c]);
            chk($sformatf("rpm_b_ch%0d", c), rpm_b[c*8 +: 8],   exp_rpm[1][c]);
            chk($sformatf("rpm_c_ch%0d", c), rpm_c[c*8 +: 8],   exp_rpm[2][c]);
         end
      end
   end

   // Pin driver: deterministic waveforms per mode, random levels in mode 4.
   int drv_last = -1, drv_ph = 0;
   int hold [2];
   initial begin
      hold[0] = 0; hold[1] = 0;
      forever begin
         @(negedge clk);
         if (mode != drv_last) begin drv_ph = 0; drv_last = mode; end
         else drv_ph++;
         case (mode)
            1: tach = {1'b0, (drv_ph % 16) < 8};
            2: tach = {1'b0, (drv_ph % 16) < 4};
            3: tach = {drv_ph < 12, 1'b0};
            4: for (int c = 0; c < 2; c++) begin
                  if (hold[c] == 0) begin
                     tach[c] = 1'($urandom_range(0, 1));
                     hold[c] = $urandom_range(1, 14);
                  end
                  hold[c]--;
               end
            default: tach = 2'b00;
         endcase
      end
   end

   task automatic wait_strobe(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!vld_a && n < 400);
      if (!vld_a) chk("strobe_timeout", vld_a, 1);
   endtask

   int n;
   initial begin
      repeat (10) @(negedge clk);
      chk("reset_rpm", rpm_a, 0);
      chk("reset_valid", vld_a, 0);
      chk("reset_stall", st_a, 0);
      rst_n = 1'b1;

      // Idle from reset: latency and stall onset.
      wait_strobe(n);
      chk("first_strobe_latency", n, 80);
      chk("idle_rpm", rpm_a, 0);
      chk("idle_stall_1", st_a, 0);
      wait_strobe(n);
      chk("idle_stall_2", st_a, 0);
      wait_strobe(n);
      chk("idle_stall_3", st_a, 2'b11);

      // Nominal 16-cycle period on ch0, plus saturating variants.
      mode = 1;
      repeat (3) wait_strobe(n);
      chk("nom_rpm_ch0", rpm_a[20:0], 300);
      chk("nom_rpm_ch1", rpm_a[41:21], 0);
      chk("nom_ovf", ov_a, 0);
      chk("nom_stall", st_a, 2'b10);
      chk("sat_rpm_b", rpm_b[7:0], 180);
      chk("sat_ovf_b", ov_b, 2'b01);
      chk("sat_rpm_c", rpm_c[7:0], 255);

      // One-tick glitches are rejected.
      mode = 2;
      repeat (4) wait_strobe(n);
      chk("glitch_rpm", rpm_a[20:0], 0);
      chk("glitch_stall", st_a, 2'b11);

      // Stall recovery on ch1.
      mode = 3;
      wait_strobe(n);
      chk("recover_rpm_ch1", rpm_a[41:21], 60);
      chk("recover_stall", st_a, 2'b01);

      // Async reset mid-window after a nonzero publish.
      mode = 1;
      repeat (3) wait_strobe(n);
      chk("pre_reset_rpm", rpm_a[20:0], 300);
      repeat (40) @(negedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rpm", rpm_a, 0);
      chk("async_stall", st_a, 0);
      chk("async_ovf_b", ov_b, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      wait_strobe(n);
      chk("post_reset_latency", n, 80);

      // Random traffic against the model.
      mode = 4;
      repeat (40) wait_strobe(n);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule

// File: doc/multi_tachometer_interface.md
Name: multi_tachometer_interface

Overview:
Parametrised, multi-channel successor to the single-channel tachometer interface. It takes NUM_CH raw tachometer pulse inputs and synchronises and debounces each one. It counts rising edges over a fixed measurement window of sample ticks, then publishes a saturated RPM per channel with a window-valid strobe, stall flags and overflow flags. It sits between the motor tachometer pins and the PID speed loop.

Parameters:
NUM_CH, 2, number of independent tachometer channels (>=1)
TICK_DIV, 12500, clk_in cycles per internal sample tick (125 MHz / 10 kHz)
WINDOW_TICKS, 10000, sample ticks per measurement window (1 s at 10 kHz)
DEBOUNCE_TICKS, 2, consecutive identical samples required to change the filtered level (>=1)
CNT_WIDTH, 16, per-channel pulse counter width
RPM_SCALE, 60, RPM per counted pulse per window (60 * tick_rate / (WINDOW_TICKS * pulses_per_rev))
RPM_WIDTH, 21, per-channel RPM output width
STALL_WINDOWS, 3, consecutive zero-count windows before a stall is flagged (>=1)

Ports:
clk_in  input  1  system clock
reset_n_in  input  1  asynchronous active-low reset
tachometer_pulse_in  input  NUM_CH  raw tachometer inputs, asynchronous to clk_in
rpm_out  output  NUM_CH*RPM_WIDTH  channel c at bits [c*RPM_WIDTH +: RPM_WIDTH]
rpm_valid_out  output  1  one-cycle strobe when all rpm_out fields update
stall_out  output  NUM_CH  per-channel stall flag
overflow_out  output  NUM_CH  per-channel counter saturation flag for the last window

Behaviour:
- Reset: asynchronous on reset_n_in low; it takes effect with no clock edge and is released synchronously to clk_in. All state clears: rpm_out=0, rpm_valid_out=0, stall_out=0, overflow_out=0. The prescaler, window counter, synchronisers, debounce counters, filtered levels, pulse counters and zero-window counters also clear. Reset asserted mid-window discards the partial window.
- Prescaler: counts 0..TICK_DIV-1. tick is high for one clk_in cycle when the count equals TICK_DIV-1, then the count wraps to 0. The first tick after reset release occurs at cycle TICK_DIV.
- Input path per channel:
  - 2-FF synchroniser.
  - Debounce, evaluated only on tick cycles. If the sample differs from the filtered level, increment the debounce count; otherwise clear it. When the count reaches DEBOUNCE_TICKS, the filtered level takes the sample value and the count clears. The filtered level resets to 0.
  - A pulse is a 0->1 transition of the filtered level. Pulses of fewer than DEBOUNCE_TICKS samples are ignored.
- Window counter: increments on each tick over 0..WINDOW_TICKS-1. The window closes on the tick where the counter equals WINDOW_TICKS-1, and the counter then wraps to 0.
- Pulse counter per channel:
  - Increments on each pulse and saturates at 2^CNT_WIDTH-1.
  - A pulse arriving when the counter is already saturated sets an internal overflow bit.
  - A pulse on the closing tick counts toward the closing window.
  - At window close the counter and overflow bit restart at 0 for the new window.
- Publish, at window close, registered, visible the cycle after the closing tick:
  - rpm field = min(count*RPM_SCALE, 2^RPM_WIDTH-1). The product is computed at full width before saturating.
  - overflow_out[c] = overflow bit for the closed window.
  - rpm_valid_out is high for exactly that one cycle.
  - rpm_out and overflow_out hold until the next window close.
- Stall per channel:
  - Zero-window counter increments, saturating at STALL_WINDOWS, on each close with count==0; it clears on a close with count!=0.
  - stall_out[c] = (zero-window counter == STALL_WINDOWS). It is updated in the same cycle as rpm_valid_out.
- Channels are fully independent. Simultaneous pulses on all channels are all counted.
- No back-pressure. The consumer samples rpm_out on rpm_valid_out.

Test Plan:
(bench overrides: TICK_DIV=4, WINDOW_TICKS=20, DEBOUNCE_TICKS=2, NUM_CH=2, RPM_SCALE=60 unless noted)
1. Reset and idle: hold reset_n_in=0 for 10 cycles, then release with inputs low -> all outputs 0 during reset. First rpm_valid_out occurs 80 cycles after release with rpm_out=0 on both channels. stall_out=2'b11 appears on the 3rd strobe.
2. Nominal count: ch0 toggles 8 cycles high / 8 cycles low (2 ticks each), ch1 held low -> steady-state windows report ch0 rpm=300 (5 pulses), ch1 rpm=0, overflow_out=0.
3. Glitch rejection: ch0 pulses high for 4 cycles (1 tick) every 16 cycles -> ch0 rpm=0 every window, and stall_out[0] asserts after 3 windows.
4. Stall recovery: ch1 idle for 3 windows (stall_out[1]=1), then one debounced pulse -> next strobe gives ch1 rpm=60 and stall_out[1]=0.
5. Saturation (CNT_WIDTH=2, RPM_WIDTH=8): ch0 at 5 pulses/window -> count saturates at 3, overflow_out[0]=1, rpm=min(180,255)=180. Repeat with RPM_SCALE=100 -> rpm=255.
6. Async reset mid-window: drive reset_n_in low between clock edges halfway through a window after a nonzero publish -> rpm_out, stall_out and overflow_out go to 0 with no clock edge. After release, the next strobe comes a full 80 cycles later.
